// File: rtl/button_press_arbiter.sv
// Debounced button front end: shared tick prescaler, per-button stability filter, press arbitration
// and a valid/ready press channel with release lockout. Define ROUND_ROBIN_EN for round-robin grant.
module button_press_arbiter #(
  parameter int NUM_BTN      = 4,
  parameter int TICK_W       = 19,
  parameter int STABLE_TICKS = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_BTN-1:0]         button,
  input  logic                       arm,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [$clog2(NUM_BTN)-1:0] out_code,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic                       press_drop
);

  localparam int CODE_W = $clog2(NUM_BTN);
  localparam int CNT_W  = $clog2(STABLE_TICKS + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GRANT    = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;

  logic [TICK_W-1:0]  presc;
  logic               tick;
  logic [NUM_BTN-1:0] sync_a;
  logic [NUM_BTN-1:0] sync_b;
  logic [CNT_W-1:0]   stab_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] press;
  logic               press_multi;
  logic [CODE_W-1:0]  grant_idx;
  logic [1:0]         state;

  assign tick        = &presc;
  assign press       = btn_level & ~level_q;
  assign press_multi = |(press & (press - NUM_BTN'(1)));

  // Prescaler, synchronizers and stability filters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      sync_a    <= '0;
      sync_b    <= '0;
      btn_level <= '0;
      for (int i = 0; i < NUM_BTN; i++) stab_cnt[i] <= '0;
    end else begin
      presc  <= presc + TICK_W'(1);
      sync_a <= button;
      sync_b <= sync_a;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync_b[i] == btn_level[i]) begin
          stab_cnt[i] <= '0;
        end else if (tick) begin
          if (stab_cnt[i] == CNT_W'(STABLE_TICKS - 1)) begin
            btn_level[i] <= ~btn_level[i];
            stab_cnt[i]  <= '0;
          end else begin
            stab_cnt[i] <= stab_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef ROUND_ROBIN_EN
  logic [CODE_W-1:0]    rr_ptr;
  logic [2*NUM_BTN-1:0] press_dbl;
  logic [NUM_BTN-1:0]   press_rot;

  // Rotate so bit 0 is the index just after the last grant, then take the lowest set bit
  always_comb begin
    press_dbl = {press, press};
    press_rot = press_dbl[NUM_BTN-1:0];
    press_rot = NUM_BTN'(press_dbl >> (int'(rr_ptr) + 1));
    grant_idx = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      if (press_rot[k]) grant_idx = CODE_W'((int'(rr_ptr) + 1 + k) % NUM_BTN);
    end
  end
`else
  always_comb begin
    grant_idx = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      if (press[k]) grant_idx = CODE_W'(k);
    end
  end
`endif

  // Grant / handshake / release-lockout sequencer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_code   <= '0;
      press_drop <= 1'b0;
      level_q    <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr     <= CODE_W'(NUM_BTN - 1);
`endif
    end else begin
      level_q    <= btn_level;
      press_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (arm && (|press)) begin
            out_code   <= grant_idx;
            out_valid  <= 1'b1;
            press_drop <= press_multi;
            state      <= GRANT;
`ifdef ROUND_ROBIN_EN
            rr_ptr     <= grant_idx;
`endif
          end
        end
        GRANT: begin
          press_drop <= |press;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          press_drop <= |press;
          if (!btn_level[out_code]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
